// File: rtl/cpu_defs.sv
// Shared core definitions: widths, NOP encoding,
// stall vector bit positions and the fetch buffer entry.
package cpu_defs;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST =
    32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC_DEF =
    32'h0000_0000;

  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with flush.
// Caller guarantees no push into a full buffer.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & !empty & !flush;
  assign do_push = push & !flush;
  assign rdata   = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch front end: PC, bus issue, return buffer.
// FETCH_BYPASS_EN: forward a response straight to the output.
module if_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [5:0]  stall_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ret_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   outst_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [FW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    entry;
  fetch_entry_t    head;

  logic rsp;
  logic keep;
  logic fire;
  logic push;
  logic pop;
  logic bypass;
  logic hold_pc;
  logic hold_if;
  int   inflight;
  logic unused_bits;

  assign unused_bits =
    ^{jump_addr_i[1:0], stall_i[5:2]};

  assign hold_pc = stall_i[STALL_PC];
  assign hold_if = stall_i[STALL_IF];
  assign target  = {jump_addr_i[XLEN-1:2], 2'b00};

  // responses only count while something is in flight
  assign rsp  = ibus_rvalid_i & (outst_cnt != '0);
  assign keep = rsp & (drop_cnt == '0);

  assign inflight = int'(outst_cnt)
                  + int'(fifo_count);

  assign ibus_req_o = rst_n
                    & !jump_flag_i
                    & !hold_pc
                    & (int'(outst_cnt) < MAX_OUTST)
                    & (inflight < FIFO_DEPTH);

  assign ibus_addr_o = pc;
  assign fire = ibus_req_o & ibus_gnt_i;

`ifdef FETCH_BYPASS_EN
  assign bypass = keep & fifo_empty & !hold_if;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = !fifo_empty & !hold_if;
  assign push = keep
              & !bypass
              & !jump_flag_i
              & (!fifo_full | pop);

  assign entry = '{addr: ret_pc, inst: ibus_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (jump_flag_i),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // PC, return PC and in-flight/drop counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      ret_pc    <= RESET_PC;
      outst_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      outst_cnt <= outst_cnt + CW'(fire) - CW'(rsp);
      if (jump_flag_i) begin
        pc       <= target;
        ret_pc   <= target;
        drop_cnt <= outst_cnt - CW'(rsp);
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (keep) ret_pc <= ret_pc + 32'd4;
        if (rsp && drop_cnt != '0)
          drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // present buffer head, or the live response on bypass
  always_comb begin
    inst_o       = NOP_INST;
    inst_addr_o  = ret_pc;
    inst_valid_o = 1'b0;
    if (!fifo_empty) begin
      inst_o       = head.inst;
      inst_addr_o  = head.addr;
      inst_valid_o = 1'b1;
    end else if (bypass) begin
      inst_o       = ibus_rdata_i;
      inst_addr_o  = ret_pc;
      inst_valid_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with an in-order bus model.
// Instruction word returned for address a is ~a.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [5:0]  stall;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] addr;
  logic [31:0] inst;
  logic [31:0] iaddr;
  logic        valid;

  logic        resp_en;
  logic [31:0] pend [$];
  logic [31:0] exp_addr;
  logic [31:0] last_issue;
  logic [31:0] base;
  logic [31:0] hold;
  bit          sb_on;
  int          checks = 0;
  int          errors = 0;

  if_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .jump_flag_i   (jump_flag),
    .jump_addr_i   (jump_addr),
    .stall_i       (stall),
    .ibus_req_o    (req),
    .ibus_addr_o   (addr),
    .ibus_gnt_i    (gnt),
    .ibus_rvalid_i (rvalid),
    .ibus_rdata_i  (rdata),
    .inst_o        (inst),
    .inst_addr_o   (iaddr),
    .inst_valid_o  (valid)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] iaddr;
  } vec_t;

  vec_t tv [8];

  function automatic vec_t mk(
    input logic        r,
    input logic [31:0] a,
    input logic        v,
    input logic [31:0] ia
  );
    vec_t t;
    t.req   = r;
    t.addr  = a;
    t.valid = v;
    t.iaddr = ia;
    return t;
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    if (sb_on && valid && !stall[1]) begin
      chk("sb_addr", iaddr, exp_addr);
      chk("sb_inst", inst, ~exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
    if (rvalid) void'(pend.pop_front());
    if (req && gnt) begin
      pend.push_back(addr);
      last_issue = addr;
    end
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    rdata  = 32'h0;
    if (resp_en && pend.size() > 0) begin
      rvalid = 1'b1;
      rdata  = ~pend[0];
    end
  endtask

  task automatic step();
    #2;
    tick();
  endtask

  task automatic wait_req(
    input string       name,
    input logic [31:0] target
  );
    int n;
    n = 0;
    #2;
    while (!req && n < 10) begin
      tick();
      #2;
      n++;
    end
    chk({name, "_req"}, {31'b0, req}, 32'd1);
    chk(name, addr, target);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    jump_flag  = 1'b0;
    jump_addr  = 32'h0;
    stall      = 6'b0;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    rdata      = 32'h0;
    resp_en    = 1'b1;
    sb_on      = 1'b0;
    exp_addr   = 32'h0;
    last_issue = 32'h0;

`ifdef FETCH_BYPASS_EN
    tv[0] = mk(1'b1, 32'h00, 1'b0, 32'h00);
    for (int k = 1; k < 8; k++)
      tv[k] = mk(1'b1, 32'(4 * k),
                 1'b1, 32'(4 * (k - 1)));
`else
    tv[0] = mk(1'b1, 32'h00, 1'b0, 32'h00);
    tv[1] = mk(1'b1, 32'h04, 1'b0, 32'h00);
    tv[2] = mk(1'b0, 32'h00, 1'b1, 32'h00);
    tv[3] = mk(1'b1, 32'h08, 1'b1, 32'h04);
    tv[4] = mk(1'b1, 32'h0c, 1'b0, 32'h00);
    tv[5] = mk(1'b0, 32'h00, 1'b1, 32'h08);
    tv[6] = mk(1'b1, 32'h10, 1'b1, 32'h0c);
    tv[7] = mk(1'b1, 32'h14, 1'b0, 32'h00);
`endif

    @(posedge clk);
    #1;
    step();
    step();

    // reset values
    #2;
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_iaddr", iaddr, 32'h0);
    tick();

    // zero-wait startup, cycle by cycle
    rst_n = 1'b1;
    gnt   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk($sformatf("tv%0d_req", i),
          {31'b0, req}, {31'b0, tv[i].req});
      if (tv[i].req)
        chk($sformatf("tv%0d_addr", i),
            addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i),
          {31'b0, valid}, {31'b0, tv[i].valid});
      if (tv[i].valid) begin
        chk($sformatf("tv%0d_iaddr", i),
            iaddr, tv[i].iaddr);
        chk($sformatf("tv%0d_inst", i),
            inst, ~tv[i].iaddr);
      end
      tick();
    end

`ifdef FETCH_BYPASS_EN
    exp_addr = 32'h1c;
`else
    exp_addr = 32'h10;
`endif
    sb_on = 1'b1;

    // hold IF output: buffer fills, issue stops
    stall = 6'b000010;
    for (int i = 0; i < 4; i++) step();
    #2;
    chk("stall_req", {31'b0, req}, 32'd0);
    chk("stall_valid", {31'b0, valid}, 32'd1);
    chk("stall_head", iaddr, exp_addr);
    tick();
    stall = 6'b0;
    base  = exp_addr;
    repeat (12) step();
    chk("stall_resume",
        {31'b0, exp_addr >= base + 32'd20}, 32'd1);

    // two in flight, then redirect to 0x100
    resp_en = 1'b0;
    repeat (6) step();
    #2;
    chk("j1_full_req", {31'b0, req}, 32'd0);
    chk("j1_empty", {31'b0, valid}, 32'd0);
    chk("j1_outst", pend.size(), 32'd2);
    jump_flag = 1'b1;
    jump_addr = 32'h100;
    resp_en   = 1'b1;
    #1;
    chk("j1_req_forced", {31'b0, req}, 32'd0);
    tick();
    jump_flag = 1'b0;
    exp_addr  = 32'h100;
    #2;
    chk("j1_flushed", {31'b0, valid}, 32'd0);
    tick();
    wait_req("j1_target", 32'h100);
    repeat (10) step();
    chk("j1_progress",
        {31'b0, exp_addr >= 32'h110}, 32'd1);

    // unaligned target is word aligned
    jump_flag = 1'b1;
    jump_addr = 32'h203;
    step();
    jump_flag = 1'b0;
    exp_addr  = 32'h200;
    wait_req("j2_align", 32'h200);
    repeat (8) step();
    chk("j2_progress",
        {31'b0, exp_addr >= 32'h208}, 32'd1);

    // grant withheld: address stays put
    gnt = 1'b0;
    repeat (4) step();
    hold = last_issue + 32'd4;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("wait%0d_req", i),
          {31'b0, req}, 32'd1);
      chk($sformatf("wait%0d_addr", i),
          addr, hold);
      tick();
    end
    jump_flag = 1'b1;
    jump_addr = 32'h300;
    #2;
    chk("j3_req_low", {31'b0, req}, 32'd0);
    tick();
    jump_flag = 1'b0;
    gnt       = 1'b1;
    exp_addr  = 32'h300;
    #2;
    chk("j3_req", {31'b0, req}, 32'd1);
    chk("j3_addr", addr, 32'h300);
    tick();
    repeat (8) step();
    chk("j3_progress",
        {31'b0, exp_addr >= 32'h308}, 32'd1);

    // reset with two responses still in flight
    resp_en = 1'b0;
    repeat (6) step();
    chk("r_outst", pend.size(), 32'd2);
    rst_n   = 1'b0;
    resp_en = 1'b1;
    gnt     = 1'b0;
    sb_on   = 1'b0;
    step();
    #2;
    chk("r_req", {31'b0, req}, 32'd0);
    chk("r_valid", {31'b0, valid}, 32'd0);
    chk("r_inst", inst, NOP);
    chk("r_iaddr", iaddr, 32'h0);
    tick();
    rst_n = 1'b1;
    #2;
    chk("r_restart_req", {31'b0, req}, 32'd1);
    chk("r_restart_addr", addr, 32'h0);
    tick();
    #2;
    chk("r_stale_valid", {31'b0, valid}, 32'd0);
    chk("r_stale_gone", pend.size(), 32'd0);
    gnt      = 1'b1;
    sb_on    = 1'b1;
    exp_addr = 32'h0;
    tick();
    repeat (10) step();
    chk("r_progress",
        {31'b0, exp_addr >= 32'h10}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
